instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage: owns the PC, fetches 32-bit instructions over a req/ack imem port,
//  and presents one held instruction at a time to ctrl_unit/regfile/imm_gen.
//  Consumes the core's redirect (pc_sel from ctrl_unit, target from ALU) at each commit.
//  Keeps a retired-instruction counter and a sticky misaligned-target error.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset
//  NOP_INSN   32'h0000_0013   value driven on o_instr while not valid (addi x0,x0,0)
// PORTS
//  i_clk         in   1   clock, all state updates on rising edge
//  i_reset       in   1   synchronous, active-low reset
//  o_imem_req    out  1   fetch request, held high until acked
//  o_imem_addr   out  32  fetch address (= current PC), stable while o_imem_req
//  i_imem_ack    in   1   imem returns data this cycle (may be same cycle as req)
//  i_imem_rdata  in   32  instruction word, sampled only when req & ack
//  i_commit      in   1   core has executed o_instr this cycle; advance PC
//  i_pc_sel      in   1   1: redirect to i_alu_data; 0: PC+4
//  i_alu_data    in   32  jump/branch target from ALU
//  o_instr       out  32  held instruction, NOP_INSN when not valid
//  o_instr_vld   out  1   o_instr/o_pc valid for execution
//  o_pc          out  32  PC of o_instr
//  o_pc_four     out  32  o_pc + 4 (mod 2^32), for JAL/JALR writeback
//  o_retire_cnt  out  32  number of committed instructions, wraps
//  o_fetch_err   out  1   sticky misaligned-target flag
// BEHAVIOUR
//  Reset (i_reset==0 at edge): state=S_IDLE, pc=RESET_PC, instr reg=NOP_INSN, retire_cnt=0,
//   fetch_err=0; outputs: o_imem_req=0, o_instr_vld=0, o_instr=NOP_INSN, o_pc=RESET_PC.
//   Reset mid-fetch drops o_imem_req next cycle; stale acks are ignored.
//  FSM (state register, next-state combinational):
//   S_IDLE : req=0, vld=0. -> S_REQ unconditionally (one bubble after reset).
//   S_REQ  : req=1, addr=pc, vld=0. If i_imem_ack: latch i_imem_rdata, -> S_VALID; else stay.
//   S_VALID: req=0, vld=1, o_instr=latched word. If i_commit: pc<=next_pc, retire_cnt++,
//            -> S_REQ (or S_ERR if target misaligned); else hold everything.
//   S_ERR  : req=0, vld=0, o_fetch_err=1; stays until reset.
//  next_pc = i_pc_sel ? {i_alu_data[31:1],1'b0} : pc+4; add is 32-bit, wraps at 2^32.
//  Misaligned: i_pc_sel & i_alu_data[1]==1 at commit -> fetch_err<=1, pc<=target, -> S_ERR,
//   retire_cnt still increments (the jump/branch itself committed).
//  i_imem_ack outside S_REQ ignored; i_commit outside S_VALID ignored.
//  i_pc_sel/i_alu_data sampled only on the commit edge.
//  Latency: zero-wait imem -> req cycle N, vld cycle N+1; commit at N+1 -> next req at N+2.
//   Peak throughput 1 instruction / 2 cycles; each imem wait cycle adds one.
//  o_pc/o_pc_four/o_instr stable for the whole S_VALID interval.
//  retire_cnt wraps 32'hFFFF_FFFF -> 0 silently.
// TESTING
//  1 Reset, ack tied 1, commit tied 1, pc_sel=0 -> req cycle 1 addr 0, vld cycle 2 pc=0,
//    then pc=4,8,12 every 2 cycles; o_pc_four=pc+4; retire_cnt counts 1,2,3.
//  2 Imem ack delayed 3 cycles -> req/addr held 3 cycles, vld=0, o_instr=32'h13; data
//    32'h00500093 appears on o_instr the cycle after ack.
//  3 At pc=8 commit with pc_sel=1, alu_data=32'h0000_0101 -> next addr 32'h100 (bit0 cleared);
//    pc=32'hFFFF_FFFC, pc_sel=0 -> next addr 0 (wrap).
//  4 Commit with pc_sel=1, alu_data=32'h0000_0202 -> o_fetch_err=1, vld=0, req=0 held;
//    retire_cnt incremented; only reset clears it.
//  5 Reset asserted while in S_REQ awaiting ack -> req=0 next cycle, pc=RESET_PC,
//    late ack ignored; fetch restarts at RESET_PC after S_IDLE bubble.
//  6 Hold commit low 5 cycles in S_VALID -> o_instr/o_pc unchanged, no new req, cnt unchanged.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch stage. Owns the PC, fetches one 32-bit word at a time
//   over a req/ack instruction-memory port, and holds that word for the core
//   until the core commits it. On commit it advances the PC, either to PC+4
//   or to the ALU target. A retired-instruction counter and a sticky
//   misaligned-target error flag are kept alongside.
//
// Ports
//   i_clk, i_reset      clock (rising edge) and synchronous active-low reset
//   o_imem_req          fetch request, held high until acked
//   o_imem_addr         fetch address (current PC)
//   i_imem_ack          imem returns i_imem_rdata this cycle
//   i_imem_rdata        instruction word
//   i_commit            core executed o_instr this cycle
//   i_pc_sel            1: redirect to i_alu_data, 0: PC+4
//   i_alu_data          jump/branch target
//   o_instr             held instruction, NOP_INSN when not valid
//   o_instr_vld         o_instr / o_pc valid for execution
//   o_pc, o_pc_four     PC of o_instr and PC+4
//   o_retire_cnt        committed-instruction count (wraps)
//   o_fetch_err         sticky misaligned-target flag
//   o_dbg_state         current FSM state, for observation only
//
// Handshakes: an imem transfer happens on a rising edge where o_imem_req and
// i_imem_ack are both high (ack may arrive in the same cycle as req, and
// req/addr stay stable until then). An instruction transfer to the core
// happens on a rising edge where o_instr_vld and i_commit are both high; acks
// and commits seen at any other time are ignored.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_commit,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  output logic [31:0] o_instr,
  output logic        o_instr_vld,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic [31:0] o_retire_cnt,
  output logic        o_fetch_err,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] instr_q;
  logic [31:0] retire_cnt;
  logic        fetch_err;
  logic        do_fetch;
  logic        do_commit;
  logic        misaligned;

  assign pc_plus4  = pc + 32'd4;
  assign do_fetch  = (state == S_REQ) && i_imem_ack;
  assign do_commit = (state == S_VALID) && i_commit;

  // Bit 0 of a redirect target is always dropped (JALR semantics); bit 1
  // set means the target is not word aligned and fetching stops for good.
  assign next_pc    = i_pc_sel ? {i_alu_data[31:1], 1'b0} : pc_plus4;
  assign misaligned = i_pc_sel && i_alu_data[1];

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_REQ;
      S_REQ:   if (i_imem_ack) next_state = S_VALID;
      S_VALID: if (i_commit) next_state = misaligned ? S_ERR : S_REQ;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      instr_q    <= NOP_INSN;
      retire_cnt <= 32'd0;
      fetch_err  <= 1'b0;
    end else begin
      state <= next_state;
      if (do_fetch) begin
        instr_q <= i_imem_rdata;
      end
      if (do_commit) begin
        pc         <= next_pc;
        retire_cnt <= retire_cnt + 32'd1;
        if (misaligned) begin
          fetch_err <= 1'b1;
        end
      end
    end
  end

  assign o_imem_req   = (state == S_REQ);
  assign o_imem_addr  = pc;
  assign o_instr_vld  = (state == S_VALID);
  assign o_instr      = o_instr_vld ? instr_q : NOP_INSN;
  assign o_pc         = pc;
  assign o_pc_four    = pc_plus4;
  assign o_retire_cnt = retire_cnt;
  assign o_fetch_err  = fetch_err;
  assign o_dbg_state  = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        commit;
  logic        pc_sel;
  logic [31:0] alu_data;
  logic [31:0] instr;
  logic        instr_vld;
  logic [31:0] pc;
  logic [31:0] pc_four;
  logic [31:0] retire_cnt;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  // imem model: word = address ^ KEY unless a fixed word is forced
  logic        force_word;
  logic [31:0] forced_word;
  assign imem_rdata = force_word ? forced_word : (imem_addr ^ KEY);

  int total;
  int bad;

  instr_fetch_unit dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .i_commit     (commit),
    .i_pc_sel     (pc_sel),
    .i_alu_data   (alu_data),
    .o_instr      (instr),
    .o_instr_vld  (instr_vld),
    .o_pc         (pc),
    .o_pc_four    (pc_four),
    .o_retire_cnt (retire_cnt),
    .o_fetch_err  (fetch_err),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    check_eq({tag, " req"}, {31'd0, imem_req}, 32'd1);
    check_eq({tag, " addr"}, imem_addr, addr);
    check_eq({tag, " vld"}, {31'd0, instr_vld}, 32'd0);
    check_eq({tag, " nop"}, instr, NOP);
  endtask

  task automatic expect_vld(input string tag, input logic [31:0] p, input logic [31:0] w);
    check_eq({tag, " vld"}, {31'd0, instr_vld}, 32'd1);
    check_eq({tag, " req"}, {31'd0, imem_req}, 32'd0);
    check_eq({tag, " pc"}, pc, p);
    check_eq({tag, " pc4"}, pc_four, p + 32'd4);
    check_eq({tag, " instr"}, instr, w);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    commit = 1'b1;
    pc_sel = 1'b0;
    alu_data = 32'd0;
    force_word = 1'b0;
    forced_word = 32'd0;

    // reset state
    step();
    step();
    check_eq("rst req", {31'd0, imem_req}, 32'd0);
    check_eq("rst vld", {31'd0, instr_vld}, 32'd0);
    check_eq("rst instr", instr, NOP);
    check_eq("rst pc", pc, 32'd0);
    check_eq("rst cnt", retire_cnt, 32'd0);
    check_eq("rst err", {31'd0, fetch_err}, 32'd0);
    check_eq("rst state", {30'd0, dbg_state}, 32'd0);

    // 1: zero-wait streaming, one instruction every 2 cycles
    rst_n = 1'b1;
    step();
    expect_req("t1 first", 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      expect_vld("t1 v", 32'(4 * k), 32'(4 * k) ^ KEY);
      step();
      expect_req("t1 r", 32'(4 * k + 4));
      check_eq("t1 cnt", retire_cnt, 32'(k + 1));
    end

    // 2: imem ack delayed 3 cycles at addr 16
    imem_ack = 1'b0;
    commit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_req("t2 wait", 32'd16);
    end
    imem_ack = 1'b1;
    force_word = 1'b1;
    forced_word = 32'h0050_0093;
    step();
    expect_vld("t2 data", 32'd16, 32'h0050_0093);
    force_word = 1'b0;

    // 6: commit held low for 5 cycles, stray acks ignored
    for (int k = 0; k < 5; k++) begin
      step();
      expect_vld("t6 hold", 32'd16, 32'h0050_0093);
      check_eq("t6 cnt", retire_cnt, 32'd4);
    end

    // 3: redirect with bit0 cleared, then PC wrap at 2^32
    commit = 1'b1;
    pc_sel = 1'b1;
    alu_data = 32'h0000_0101;
    step();
    expect_req("t3 redir", 32'h0000_0100);
    check_eq("t3 cnt5", retire_cnt, 32'd5);
    pc_sel = 1'b0;
    step();
    expect_vld("t3 v100", 32'h0000_0100, 32'h0000_0100 ^ KEY);
    pc_sel = 1'b1;
    alu_data = 32'hFFFF_FFFC;
    step();
    expect_req("t3 top", 32'hFFFF_FFFC);
    step();
    expect_vld("t3 vtop", 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ KEY);
    pc_sel = 1'b0;
    step();
    expect_req("t3 wrap", 32'd0);
    check_eq("t3 cnt7", retire_cnt, 32'd7);
    step();
    expect_vld("t3 v0", 32'd0, KEY);

    // 4: misaligned target -> sticky error
    pc_sel = 1'b1;
    alu_data = 32'h0000_0202;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t4 err", {31'd0, fetch_err}, 32'd1);
      check_eq("t4 vld", {31'd0, instr_vld}, 32'd0);
      check_eq("t4 req", {31'd0, imem_req}, 32'd0);
      check_eq("t4 cnt", retire_cnt, 32'd8);
      check_eq("t4 pc", pc, 32'h0000_0202);
      check_eq("t4 instr", instr, NOP);
      check_eq("t4 state", {30'd0, dbg_state}, 32'd3);
    end

    // 5: reset clears error; reset while awaiting ack, late ack ignored
    pc_sel = 1'b0;
    commit = 1'b0;
    rst_n = 1'b0;
    step();
    check_eq("t5 err clr", {31'd0, fetch_err}, 32'd0);
    check_eq("t5 cnt clr", retire_cnt, 32'd0);
    rst_n = 1'b1;
    imem_ack = 1'b0;
    step();
    step();
    expect_req("t5 waiting", 32'd0);
    rst_n = 1'b0;
    imem_ack = 1'b1;
    step();
    check_eq("t5 req drop", {31'd0, imem_req}, 32'd0);
    check_eq("t5 vld", {31'd0, instr_vld}, 32'd0);
    check_eq("t5 pc", pc, 32'd0);
    check_eq("t5 instr", instr, NOP);
    rst_n = 1'b1;
    step();
    expect_req("t5 restart", 32'd0);
    step();
    expect_vld("t5 v0", 32'd0, KEY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
